lc3_mem_arbiter: RTL

- Shares the single-port LC-3 main memory between two requesters: the CPU memory port (MAR/MDR/memWE path) and a debug/loader port used by the bench to preload and inspect memory.
- Sits between the controller/datapath and the memory model, and sequences every access as issue, wait and respond.
- The CPU has fixed priority. A starvation counter guarantees the debug port a slot.

---
 rtl/lc3_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter
// Purpose  : Shares single-port LC-3 main memory between the CPU port and a
//            debug/loader port; fixed CPU priority with debug starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [2:0] C_LAT_M1       = 3'(MEM_LAT - 1);
  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] C_OWN_NONE     = 2'b00;
  localparam logic [1:0] C_OWN_CPU      = 2'b01;
  localparam logic [1:0] C_OWN_DBG      = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic [2:0]        r_wait;
  logic [3:0]        r_starve;
  logic              w_grant_dbg;
  logic              w_grant_cpu;

  // Debug wins only when the CPU is quiet or has been served its quota.
  assign w_grant_dbg = dbg_req && (!cpu_req || (r_starve == C_STARVE_LIMIT));
  assign w_grant_cpu = cpu_req && !w_grant_dbg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dbg_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dbg || w_grant_cpu) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_we = r_we;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == 3'd0) w_next = S_RESP;
      end
      S_RESP: begin
        cpu_ack = (r_owner == C_OWN_CPU);
        dbg_ack = (r_owner == C_OWN_DBG);
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= C_OWN_NONE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_wait      <= '0;
      r_starve    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!dbg_req) r_starve <= '0;
          if (w_grant_dbg) begin
            r_owner  <= C_OWN_DBG;
            r_we     <= dbg_we;
            r_addr   <= dbg_addr;
            r_wdata  <= dbg_wdata;
            r_starve <= '0;
          end else if (w_grant_cpu) begin
            r_owner <= C_OWN_CPU;
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (dbg_req && (r_starve != C_STARVE_LIMIT)) r_starve <= r_starve + 4'd1;
          end else begin
            r_owner <= C_OWN_NONE;
          end
        end
        S_ISSUE: r_wait <= C_LAT_M1;
        S_WAIT: begin
          // Memory data is only trusted on the final wait cycle.
          if (r_wait == 3'd0) begin
            if (!r_we && (r_owner == C_OWN_CPU)) r_cpu_rdata <= mem_rdata;
            if (!r_we && (r_owner == C_OWN_DBG)) r_dbg_rdata <= mem_rdata;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_RESP: r_owner <= C_OWN_NONE;
        default: r_owner <= C_OWN_NONE;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign owner     = r_owner;

endmodule
`default_nettype wire
